pipelined_mem_responder: RTL

- Memory-side responder for cache-fill read traffic.
- Accepts one read or write request per cycle with no backpressure.
- Returns each read's data after exactly LATENCY cycles with a one-cycle valid strobe, so a fill FSM can stream 8 back-to-back reads.
- Sits below the I/D caches as the unified main-memory model and controller; 16-bit words, byte-addressed.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_delay_pipe.sv | 40 ++++
 rtl/pipelined_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the unified main-memory responder: word geometry,
// cache-block shape, default read latency and burst FSM state encoding.
package mem_pkg;

    localparam int WORD_W          = 16;
    localparam int BLOCK_WORDS     = 8;
    localparam int OFFSET_W        = 3;
    localparam int DEFAULT_LATENCY = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef struct packed {
        logic              vld;
        logic [WORD_W-1:0] data;
    } pipe_entry_t;

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-latency {valid,data} delay line; always shifts, never stalls.
// Only the valid bits are cleared by the synchronous active-low reset.
module mem_delay_pipe #(
    parameter int LATENCY = 4,
    parameter int WIDTH   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data lanes carry no reset; a stale word is harmless while its valid is low.
    always_ff @(posedge clk_i) begin
        data_q[0] <= data_i;
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign vld_o  = vld_q[LATENCY-1];
    assign data_o = data_q[LATENCY-1];

endmodule

// File: rtl/pipelined_mem_responder.sv
// Unified main-memory model: single-cycle request acceptance, fixed-latency
// read return. Define MEM_BURST_EN to add the 8-word cache-block burst port.
module pipelined_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
`ifdef MEM_BURST_EN
    input  logic              burst,
`endif
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);

    logic [WORD_W-1:0]     mem_q [2**DEPTH_LOG2];
    logic                  rd_vld;
    logic [WORD_W-1:0]     rd_addr;
    logic                  do_wr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  pipe_vld;
    logic [WORD_W-1:0]     pipe_data;
    logic                  unused_addr;

    assign unused_addr = ^addr;

`ifdef MEM_BURST_EN
    logic [0:0]                 state_q, state_d;
    logic [OFFSET_W-1:0]        cnt_q, cnt_d;
    logic [WORD_W-OFFSET_W-2:0] base_q, base_d;

    // In BURST the counter owns the read port and external requests are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        rd_vld  = enable & ~wr;
        rd_addr = addr;
        do_wr   = enable & wr;
        case (state_q)
            ST_IDLE: begin
                if (enable && !wr && burst) begin
                    state_d = ST_BURST;
                    cnt_d   = 3'd1;
                    base_d  = addr[WORD_W-1:OFFSET_W+1];
                    rd_addr = {addr[WORD_W-1:OFFSET_W+1], {OFFSET_W{1'b0}}, 1'b0};
                end
            end
            default: begin
                do_wr   = 1'b0;
                rd_vld  = 1'b1;
                rd_addr = {base_q, cnt_q, 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == {OFFSET_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

    assign busy = (state_q == ST_BURST);
`else
    assign rd_vld  = enable & ~wr;
    assign rd_addr = addr;
    assign do_wr   = enable & wr;
    assign busy    = 1'b0;
`endif

    assign rd_idx = rd_addr[DEPTH_LOG2:1];
    assign wr_idx = addr[DEPTH_LOG2:1];

    // Reads sample the pre-write contents, so a same-edge write never leaks in.
    always_ff @(posedge clk) begin
        if (rst && do_wr) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    mem_delay_pipe #(
        .LATENCY (LATENCY),
        .WIDTH   (WORD_W)
    ) u_pipe (
        .clk_i  (clk),
        .rst_ni (rst),
        .vld_i  (rd_vld),
        .data_i (mem_q[rd_idx]),
        .vld_o  (pipe_vld),
        .data_o (pipe_data)
    );

    assign data_valid = pipe_vld;
    assign data_out   = pipe_vld ? pipe_data : '0;

endmodule
